// File: rtl/pipe_stage_chain.sv
// Parametrised chain of pipeline registers. It supports per-stage stall and
// flush, tracks a valid bit per stage, inserts bubbles and counts them.
module pipe_stage_chain #(
   parameter int               WIDTH     = 32,
   parameter int               STAGES    = 4,
   parameter logic [WIDTH-1:0] NOP_VALUE = '0,
   parameter int               CNT_W     = 16
) (
   input  logic                        clk,
   input  logic                        R,
   input  logic [WIDTH-1:0]            in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [STAGES-1:0]           stall,
   input  logic [STAGES-1:0]           flush,
   output logic [WIDTH*STAGES-1:0]     stage_data,
   output logic [STAGES-1:0]           stage_valid,
   output logic [WIDTH-1:0]            out_data,
   output logic                        out_valid,
   output logic [$clog2(STAGES+1)-1:0] occupancy,
   output logic [CNT_W-1:0]            bubble_count
);

   localparam int OCC_W = $clog2(STAGES+1);
   localparam int INC_W = $clog2(STAGES);
   localparam int SUM_W = CNT_W + INC_W;
   localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

   logic [STAGES-1:0] hold;
   logic [INC_W-1:0]  bubble_inc;
   logic [SUM_W-1:0]  bubble_sum;
   logic [CNT_W-1:0]  bubble_reg;
   logic [CNT_W-1:0]  bubble_next;

   // A stall at stage k backs up into every earlier stage.
   assign hold[STAGES-1] = stall[STAGES-1];
   genvar gi;
   generate
      for (gi = 0; gi < STAGES-1; gi++) begin : g_hold
         assign hold[gi] = stall[gi] | hold[gi+1];
      end
   endgenerate

   assign in_ready = ~hold[0];

   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         logic [WIDTH-1:0] data_reg;
         logic             valid_reg;

         if (gi == 0) begin : g_head
            always_ff @(posedge clk or posedge R) begin
               if (R) begin
                  data_reg  <= NOP_VALUE;
                  valid_reg <= 1'b0;
               end else if (flush[0]) begin
                  data_reg  <= NOP_VALUE;
                  valid_reg <= 1'b0;
               end else if (!hold[0]) begin
                  data_reg  <= in_data;
                  valid_reg <= in_valid;
               end
            end
         end else begin : g_body
            always_ff @(posedge clk or posedge R) begin
               if (R) begin
                  data_reg  <= NOP_VALUE;
                  valid_reg <= 1'b0;
               end else if (flush[gi]) begin
                  data_reg  <= NOP_VALUE;
                  valid_reg <= 1'b0;
               end else if (!hold[gi]) begin
                  if (hold[gi-1]) begin
                     data_reg  <= NOP_VALUE;
                     valid_reg <= 1'b0;
                  end else begin
                     data_reg  <= stage_data[WIDTH*(gi-1) +: WIDTH];
                     valid_reg <= stage_valid[gi-1];
                  end
               end
            end
         end

         assign stage_data[WIDTH*gi +: WIDTH] = data_reg;
         assign stage_valid[gi]               = valid_reg;
      end
   endgenerate

   assign out_data  = stage_data[WIDTH*(STAGES-1) +: WIDTH];
   assign out_valid = stage_valid[STAGES-1];

   always_comb begin
      occupancy = '0;
      for (int k = 0; k < STAGES; k++)
         occupancy = occupancy + OCC_W'(stage_valid[k]);
   end

   // Bubbles come from a moving stage directly behind a held one. NOPs that a
   // flush creates are not counted.
   always_comb begin
      bubble_inc = '0;
      for (int k = 1; k < STAGES; k++)
         if (!flush[k] && !hold[k] && hold[k-1])
            bubble_inc = bubble_inc + INC_W'(1);
   end

   assign bubble_sum  = SUM_W'(bubble_reg) + SUM_W'(bubble_inc);
   assign bubble_next = (bubble_sum > CNT_MAX) ? {CNT_W{1'b1}} : bubble_sum[CNT_W-1:0];

   always_ff @(posedge clk or posedge R) begin
      if (R) bubble_reg <= '0;
      else   bubble_reg <= bubble_next;
   end

   assign bubble_count = bubble_reg;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain. It runs directed test-plan steps and
// then random traffic, all checked against an array-based reference model.
module tb_pipe_stage_chain;

   logic        clk = 1'b0;
   logic        R = 1'b1;
   logic [31:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic [3:0]  stall = '0;
   logic [3:0]  flush = '0;

   logic         in_ready, out_valid, s_in_ready, s_out_valid;
   logic [127:0] stage_data, s_stage_data;
   logic [3:0]   stage_valid, s_stage_valid;
   logic [31:0]  out_data, s_out_data;
   logic [2:0]   occupancy, s_occupancy;
   logic [15:0]  bubble_count;
   logic [1:0]   s_bubble_count;

   int passed = 0;
   int total  = 0;

   logic [31:0] m_data [4];
   logic        m_valid [4];
   int          m_bub, m_sat;

   pipe_stage_chain dut (
      .clk(clk), .R(R), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .stall(stall), .flush(flush), .stage_data(stage_data), .stage_valid(stage_valid),
      .out_data(out_data), .out_valid(out_valid), .occupancy(occupancy),
      .bubble_count(bubble_count)
   );

   pipe_stage_chain #(.CNT_W(2)) dut_sat (
      .clk(clk), .R(R), .in_data(in_data), .in_valid(in_valid), .in_ready(s_in_ready),
      .stall(stall), .flush(flush), .stage_data(s_stage_data), .stage_valid(s_stage_valid),
      .out_data(s_out_data), .out_valid(s_out_valid), .occupancy(s_occupancy),
      .bubble_count(s_bubble_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   // A stage is frozen when it or any later stage is stalled.
   function automatic logic frozen(input int k);
      for (int j = k; j < 4; j++) if (stall[j]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int pop();
      int n = 0;
      for (int k = 0; k < 4; k++) n += int'(m_valid[k]);
      return n;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         m_data[k]  = '0;
         m_valid[k] = 1'b0;
      end
      m_bub = 0;
      m_sat = 0;
   endtask

   task automatic model_edge();
      logic [31:0] nd [4];
      logic        nv [4];
      int          nb = 0;
      for (int k = 0; k < 4; k++) begin
         if (flush[k]) begin
            nd[k] = '0; nv[k] = 1'b0;
         end else if (frozen(k)) begin
            nd[k] = m_data[k]; nv[k] = m_valid[k];
         end else if (k == 0) begin
            nd[k] = in_data; nv[k] = in_valid;
         end else if (frozen(k-1)) begin
            nd[k] = '0; nv[k] = 1'b0; nb++;
         end else begin
            nd[k] = m_data[k-1]; nv[k] = m_valid[k-1];
         end
      end
      for (int k = 0; k < 4; k++) begin
         m_data[k]  = nd[k];
         m_valid[k] = nv[k];
      end
      m_bub = (m_bub + nb > 65535) ? 65535 : m_bub + nb;
      m_sat = (m_sat + nb > 3) ? 3 : m_sat + nb;
   endtask

   task automatic check_comb();
      chk("in_ready", in_ready, !frozen(0));
      chk("sat_in_ready", s_in_ready, !frozen(0));
   endtask

   task automatic check_state();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("stage_data[%0d]", k), stage_data[32*k +: 32], m_data[k]);
         chk($sformatf("stage_valid[%0d]", k), stage_valid[k], m_valid[k]);
      end
      chk("out_data", out_data, m_data[3]);
      chk("out_valid", out_valid, m_valid[3]);
      chk("occupancy", occupancy, pop());
      chk("bubble_count", bubble_count, m_bub);
      chk("sat_bubble_count", s_bubble_count, m_sat);
   endtask

   // Inputs are set one time unit after a rising edge. Each call covers one edge.
   task automatic tick();
      #1 check_comb();
      @(posedge clk);
      model_edge();
      #1 check_state();
   endtask

   task automatic drive(input logic [31:0] d, input logic v, input logic [3:0] s, input logic [3:0] f);
      in_data = d; in_valid = v; stall = s; flush = f;
   endtask

   task automatic fill(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3);
      drive(d3, 1, 0, 0); tick();
      drive(d2, 1, 0, 0); tick();
      drive(d1, 1, 0, 0); tick();
      drive(d0, 1, 0, 0); tick();
   endtask

   initial begin
      model_reset();
      #1 check_state();
      chk("reset_in_ready", in_ready, 1'b1);
      #1 R = 1'b0;

      // Streaming 1..5, then idle while they drain.
      for (int e = 1; e <= 8; e++) begin
         drive(e <= 5 ? 32'(e) : 32'd0, e <= 5, 0, 0);
         tick();
         if (e >= 4) begin
            chk($sformatf("stream_out_data_e%0d", e), out_data, 32'(e-3));
            chk($sformatf("stream_out_valid_e%0d", e), out_valid, 1'b1);
         end
      end

      // A single-cycle stall at stage 1 leaves a bubble in stage 2.
      fill(32'h11, 32'h22, 32'h33, 32'h44);
      drive(32'h99, 1, 4'b0010, 0);
      #1 chk("stall_in_ready", in_ready, 1'b0);
      tick();
      chk("stall_s0", stage_data[31:0], 32'h11);
      chk("stall_s1", stage_data[63:32], 32'h22);
      chk("stall_s2", stage_data[95:64], 32'h0);
      chk("stall_v2", stage_valid[2], 1'b0);
      chk("stall_s3", stage_data[127:96], 32'h33);
      chk("stall_bub", bubble_count, 16'd1);

      // Flush and hold in the same cycle.
      fill(32'h11, 32'h22, 32'h33, 32'h44);
      drive(32'h99, 1, 4'b0100, 4'b0011);
      #1 chk("flush_in_ready", in_ready, 1'b0);
      tick();
      chk("flush_valid", stage_valid, 4'b0100);
      chk("flush_s0", stage_data[31:0], 32'h0);
      chk("flush_s2", stage_data[95:64], 32'h33);
      chk("flush_bub", bubble_count, 16'd2);

      // Several stall boundaries yield one bubble per cycle.
      fill(32'h11, 32'h22, 32'h33, 32'h44);
      drive(32'h99, 1, 4'b0101, 0);
      tick();
      chk("multi_valid", stage_valid, 4'b0111);
      chk("multi_bub1", bubble_count, 16'd3);
      tick(); tick(); tick();
      chk("multi_bub3", bubble_count, 16'd6);

      // Reset asserted between edges on a full pipeline.
      fill(32'hA0, 32'hA1, 32'hA2, 32'hA3);
      stall = 4'b0010;
      R = 1'b1;
      #1 model_reset();
      check_state();
      chk("midrst_valid", stage_valid, 4'b0000);
      chk("midrst_data", stage_data, 128'h0);
      chk("midrst_bub", bubble_count, 16'd0);
      chk("midrst_in_ready", in_ready, 1'b0);
      #1 R = 1'b0;
      stall = 4'b0000;

      // Saturation in the 2-bit counter.
      fill(32'h1, 32'h2, 32'h3, 32'h4);
      for (int i = 1; i <= 5; i++) begin
         drive(32'h5, 1, 4'b0001, 0);
         tick();
         chk($sformatf("sat_bub_%0d", i), s_bubble_count, (i > 3) ? 2'd3 : 2'(i));
         chk($sformatf("wide_bub_%0d", i), bubble_count, 16'(i));
      end

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         logic [3:0] s, f;
         for (int b = 0; b < 4; b++) begin
            s[b] = ($urandom_range(0, 3) == 0);
            f[b] = ($urandom_range(0, 7) == 0);
         end
         drive($urandom, 1'($urandom_range(0, 1)), s, f);
         tick();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
